// File: rtl/inst_queue.sv
// Instruction buffer between fetch and decode: a small circular FIFO of
// {pc, inst} with a valid/ready dequeue side, flush and almost-full.
module inst_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             enq_valid_i,
    input  logic [31:0]      enq_pc_i,
    input  logic [31:0]      enq_inst_i,
    output logic             enq_ready_o,
    output logic             almost_full_o,
    output logic             deq_valid_o,
    output logic [31:0]      deq_pc_o,
    output logic [31:0]      deq_inst_o,
    input  logic             deq_ready_i,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             enq_fire;
    logic             deq_fire;

    assign enq_ready_o   = (count_q != CNT_W'(DEPTH));
    assign almost_full_o = (count_q >= CNT_W'(DEPTH - 1));
    assign deq_valid_o   = (count_q != '0) && !flush_i;
    assign deq_pc_o      = pc_q[head_q];
    assign deq_inst_o    = inst_q[head_q];
    assign count_o       = count_q;

    assign enq_fire = enq_valid_i && enq_ready_o && !flush_i;
    assign deq_fire = deq_valid_o && deq_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else if (flush_i) begin
            // storage is left stale; count gates every read of it
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq_fire) begin
                pc_q[tail_q]   <= enq_pc_i;
                inst_q[tail_q] <= enq_inst_i;
                tail_q         <= tail_q + PTR_W'(1);
            end
            if (deq_fire) begin
                head_q <= head_q + PTR_W'(1);
            end
            if (enq_fire && !deq_fire) begin
                count_q <= count_q + CNT_W'(1);
            end else if (deq_fire && !enq_fire) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // The fetcher cannot stall, so an enqueue while full loses an instruction
    ovf_drop: assert property (@(posedge clk_i) disable iff (rst_i)
        !(enq_valid_i && !enq_ready_o && !flush_i))
        else $warning("inst_queue: enqueue dropped while full");

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_inst_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             flush_i = 1'b0;
    logic             enq_valid_i = 1'b0;
    logic [31:0]      enq_pc_i = '0;
    logic [31:0]      enq_inst_i = '0;
    logic             enq_ready_o;
    logic             almost_full_o;
    logic             deq_valid_o;
    logic [31:0]      deq_pc_o;
    logic [31:0]      deq_inst_o;
    logic             deq_ready_i = 1'b0;
    logic [CNT_W-1:0] count_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] model_q[$];

    inst_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .enq_valid_i  (enq_valid_i),
        .enq_pc_i     (enq_pc_i),
        .enq_inst_i   (enq_inst_i),
        .enq_ready_o  (enq_ready_o),
        .almost_full_o(almost_full_o),
        .deq_valid_o  (deq_valid_o),
        .deq_pc_o     (deq_pc_o),
        .deq_inst_o   (deq_inst_o),
        .deq_ready_i  (deq_ready_i),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        ev;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        dr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_cnt;
        logic        e_rdy;
        logic        e_af;
        logic        chk_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic flush, logic ev,
                                logic [31:0] pc, logic [31:0] inst, logic dr,
                                logic e_valid, logic [31:0] e_pc,
                                logic [31:0] e_inst, logic [31:0] e_cnt,
                                logic e_rdy, logic e_af, logic chk_data);
        vec_t v;
        v.rst = rst; v.flush = flush; v.ev = ev; v.pc = pc; v.inst = inst;
        v.dr = dr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_inst = e_inst;
        v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_af = e_af;
        v.chk_data = chk_data;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic flush, logic ev, logic [31:0] pc,
                         logic [31:0] inst, logic dr);
        rst_i = rst; flush_i = flush; enq_valid_i = ev;
        enq_pc_i = pc; enq_inst_i = inst; deq_ready_i = dr;
    endtask

    // Reference behaviour: FIFO of {pc,inst}, decisions from pre-edge size
    task automatic model_edge();
        bit do_enq, do_deq;
        if (rst_i || flush_i) begin
            model_q.delete();
        end else begin
            do_deq = (model_q.size() != 0) && deq_ready_i;
            do_enq = enq_valid_i && (model_q.size() != DEPTH);
            if (do_deq) void'(model_q.pop_front());
            if (do_enq) model_q.push_back({enq_pc_i, enq_inst_i});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        #1;
    endtask

    task automatic cycle(logic rst, logic flush, logic ev, logic [31:0] pc,
                         logic [31:0] inst, logic dr);
        drive(rst, flush, ev, pc, inst, dr);
        tick();
    endtask

    task automatic check_model(string tag);
        int sz;
        sz = model_q.size();
        chk({tag, "_valid"}, 32'(deq_valid_o), 32'(sz != 0));
        chk({tag, "_count"}, 32'(count_o), 32'(sz));
        chk({tag, "_ready"}, 32'(enq_ready_o), 32'(sz != DEPTH));
        chk({tag, "_afull"}, 32'(almost_full_o), 32'(sz >= DEPTH - 1));
        if (sz != 0) begin
            chk({tag, "_pc"}, deq_pc_o, model_q[0][63:32]);
            chk({tag, "_inst"}, deq_inst_o, model_q[0][31:0]);
        end
    endtask

    initial begin
        logic [31:0] base;
        logic [31:0] npc;

        // rst fl ev pc inst dr | valid pc inst cnt rdy af chkd
        vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0,1,0,1));
        vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,1,0,1));
        vecs.push_back(mk(0,0,1,32'h80000000,32'h413,0,
                          1,32'h80000000,32'h413,1,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,1,32'h80000000,32'h13,0,
                          1,32'h80000000,32'h13,1,1,0,1));
        vecs.push_back(mk(0,0,1,32'h80000004,32'h14,0,
                          1,32'h80000000,32'h13,2,1,0,1));
        vecs.push_back(mk(0,0,1,32'h80000008,32'h15,0,
                          1,32'h80000000,32'h13,3,1,1,1));
        vecs.push_back(mk(0,0,1,32'h8000000C,32'h16,0,
                          1,32'h80000000,32'h13,4,0,1,1));
        vecs.push_back(mk(0,0,1,32'h80000010,32'h17,0,
                          1,32'h80000000,32'h13,4,0,1,1));
        vecs.push_back(mk(0,0,0,0,0,1, 1,32'h80000004,32'h14,3,1,1,1));
        vecs.push_back(mk(0,0,0,0,0,1, 1,32'h80000008,32'h15,2,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,1, 1,32'h8000000C,32'h16,1,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,1,32'h800000A0,32'hA0,0,
                          1,32'h800000A0,32'hA0,1,1,0,1));
        vecs.push_back(mk(0,0,1,32'h800000A4,32'hA4,0,
                          1,32'h800000A0,32'hA0,2,1,0,1));
        vecs.push_back(mk(0,0,1,32'h800000A8,32'hA8,0,
                          1,32'h800000A0,32'hA0,3,1,1,1));
        vecs.push_back(mk(0,0,1,32'h800000AC,32'hAC,0,
                          1,32'h800000A0,32'hA0,4,0,1,1));
        vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0,1,0,1));

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].flush, vecs[i].ev,
                  vecs[i].pc, vecs[i].inst, vecs[i].dr);
            chk($sformatf("vec%0d_valid", i), 32'(deq_valid_o),
                32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_count", i), 32'(count_o), vecs[i].e_cnt);
            chk($sformatf("vec%0d_ready", i), 32'(enq_ready_o),
                32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_afull", i), 32'(almost_full_o),
                32'(vecs[i].e_af));
            if (vecs[i].chk_data) begin
                chk($sformatf("vec%0d_pc", i), deq_pc_o, vecs[i].e_pc);
                chk($sformatf("vec%0d_inst", i), deq_inst_o, vecs[i].e_inst);
            end
        end

        // Wrap-around: hold occupancy at 2 across ten enq+deq cycles
        base = 32'h80002000;
        cycle(0, 0, 1, base, ~base, 0);
        cycle(0, 0, 1, base + 4, ~(base + 4), 0);
        for (int k = 0; k < 10; k++) begin
            npc = base + 32'(8 + 4 * k);
            drive(0, 0, 1, npc, ~npc, 1);
            #1;
            chk($sformatf("wrap%0d_pc", k), deq_pc_o, base + 32'(4 * k));
            tick();
            chk($sformatf("wrap%0d_cnt", k), 32'(count_o), 32'd2);
        end
        check_model("wrap_end");

        // Flush with 3 queued and a competing enqueue/dequeue
        cycle(0, 0, 1, 32'h80003000, 32'h3000, 0);
        chk("preflush_cnt", 32'(count_o), 32'd3);
        drive(0, 1, 1, 32'hDEAD0000, 32'hDEAD, 1);
        #1;
        chk("flush_cycle_valid", 32'(deq_valid_o), 32'd0);
        tick();
        chk("postflush_cnt", 32'(count_o), 32'd0);
        chk("postflush_valid", 32'(deq_valid_o), 32'd0);
        chk("postflush_ready", 32'(enq_ready_o), 32'd1);
        cycle(0, 0, 1, 32'h80001000, 32'h1000, 0);
        chk("refill_valid", 32'(deq_valid_o), 32'd1);
        chk("refill_pc", deq_pc_o, 32'h80001000);
        chk("refill_cnt", 32'(count_o), 32'd1);
        check_model("refill");

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic r, f, e, d;
            logic [31:0] p;
            r = ($urandom_range(0, 79) == 0);
            f = ($urandom_range(0, 19) == 0);
            e = ($urandom_range(0, 9) < 6) &&
                (!almost_full_o || $urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 1) == 1);
            p = $urandom;
            drive(r, f, e, p, $urandom, d);
            #1;
            if (f && !r) chk("rnd_flush_valid", 32'(deq_valid_o), 32'd0);
            tick();
            check_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
Instruction buffer that sits directly downstream of the instruction fetcher and upstream of the decoder.
- Captures each fetch response (PC + instruction) into a small circular FIFO.
- Presents entries in order to decode over a valid/ready handshake.
- Decouples fetch from decode stalls.
- Discards all buffered entries on a pipeline flush (branch/exception redirect).
- Exposes almost-full so the PC/request logic can stop issuing fetches before the queue overflows, because the fetcher has no backpressure of its own.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of occupancy count

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
flush_i  input  1  discard all entries this cycle
enq_valid_i  input  1  fetch response valid (from fetcher if_resp_valid_o)
enq_pc_i  input  pc_t (32)  PC of fetched instruction
enq_inst_i  input  inst_t (32)  fetched instruction word
enq_ready_o  output  1  queue can accept an entry (not full)
almost_full_o  output  1  count >= DEPTH-1; request side must stop issuing
deq_valid_o  output  1  head entry valid toward decode
deq_pc_o  output  pc_t (32)  head entry PC
deq_inst_o  output  inst_t (32)  head entry instruction
deq_ready_i  input  1  decode accepts head this cycle
count_o  output  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Single clock. Reset is synchronous and active-high on rst_i, sampled at the rising edge of clk_i.
- Reset values:
  - head ptr = 0, tail ptr = 0, count = 0.
  - All storage entries = 0.
  - deq_valid_o = 0, deq_pc_o = 0, deq_inst_o = 0.
  - enq_ready_o = 1, almost_full_o = 0, count_o = 0.
- Storage: DEPTH entries of {pc, inst}. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- enq_ready_o = (count != DEPTH). Depends on registered state only; no combinational dependence on deq_ready_i.
- Enqueue fires when enq_valid_i && enq_ready_o && !flush_i:
  - Write {enq_pc_i, enq_inst_i} at tail; tail <= tail+1.
- enq_valid_i while full: the entry is dropped.
  - Simulation-only assertion flags overflow.
  - The request side prevents this via almost_full_o. One fetch may still be in flight when almost_full_o rises, hence the DEPTH-1 threshold.
- deq_valid_o = (count != 0) && !flush_i.
- deq_pc_o / deq_inst_o = storage[head], driven combinationally from registers.
  - Contents are don't-care when deq_valid_o = 0, but read the storage value.
- Dequeue fires when deq_valid_o && deq_ready_i: head <= head+1.
- deq_ready_i while empty: ignored, no pointer movement.
- Latency: an entry enqueued in cycle N is visible on deq_* in cycle N+1. There is no same-cycle fall-through.
- Count update:
  - +1 on enqueue only; -1 on dequeue only.
  - Unchanged on simultaneous enqueue and dequeue. This is legal whenever 0 < count < DEPTH.
  - At count == DEPTH, enqueue is blocked but dequeue proceeds.
  - At count == 0, dequeue is impossible; enqueue proceeds.
- Flush (priority below reset, above everything else):
  - head <= 0, tail <= 0, count <= 0.
  - Any same-cycle enqueue is dropped; no dequeue handshake occurs (deq_valid_o is masked).
  - Storage contents need not be cleared.
  - The cycle after flush behaves exactly as post-reset, except for storage contents.
- Reset or flush mid-stream: all in-flight entries are lost. The next accepted enqueue appears at deq_* one cycle later.
- almost_full_o = (count >= DEPTH-1), registered-state only.
- count_o = count.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles, then 0 -> deq_valid_o=0, enq_ready_o=1, almost_full_o=0, count_o=0.
- Single pass: enqueue pc=0x80000000, inst=0x00000413 with deq_ready_i=0 -> next cycle deq_valid_o=1, deq_pc_o=0x80000000, deq_inst_o=0x00000413, count_o=1. Raise deq_ready_i for 1 cycle -> following cycle deq_valid_o=0, count_o=0.
- Fill and order: with deq_ready_i=0, enqueue pcs 0x80000000..0x8000000C:
  - almost_full_o=1 after the 3rd entry; enq_ready_o=0 and count_o=4 after the 4th.
  - A 5th enq_valid_i is dropped.
  - Draining returns the 4 pcs in order, and count_o falls 4 to 0.
- Wrap-around with simultaneous enq/deq: keep count at 2 and run 10 consecutive enq+deq cycles with incrementing pcs -> count_o stays 2 and output pcs are strictly sequential across the pointer wrap.
- Flush: with 3 entries queued, assert flush_i together with enq_valid_i and deq_ready_i -> deq_valid_o=0 in that cycle. Next cycle count_o=0, deq_valid_o=0, and the flush-cycle enqueue is absent. A new enqueue of pc=0x80001000 appears at the head one cycle later.
- Reset mid-operation: with 4 entries queued, assert rst_i for 1 cycle -> all outputs return to reset values: deq_pc_o=0, deq_inst_o=0, enq_ready_o=1, count_o=0.
